// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the E stage of the MIPS pipeline.
//
// The result is computed combinationally from the operands presented at the
// start edge and parked in pending registers; HI/LO are only written when the
// busy window closes, so HI/LO stay stable and readable whenever busy=0.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu   (>=1)
//
// Ports:
//   clk      pipeline clock
//   reset_n  asynchronous active-low reset
//   start    E-stage instruction is an md op this cycle
//   md_op    000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, else no-op
//   rs_val   forwarded rs operand
//   rt_val   forwarded rt operand
//   abort    (only with MD_ABORT_EN) flush of an in-flight operation
//   busy     operation in progress (registered)
//   done     one-cycle pulse: HI/LO just updated by mult/div
//   hi, lo   HI/LO registers
//
// Build option: define MD_ABORT_EN to add the abort input.

module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic             done_q, done_d;

  // Arithmetic datapath. md_op[0]=0 selects the signed forms.
  logic        is_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = ~md_op[0];
    // Low 64 bits of the product of sign/zero-extended operands give the
    // correct signed or unsigned 32x32 result with one multiplier.
    mul_a = {{32{is_signed & rs_val[31]}}, rs_val};
    mul_b = {{32{is_signed & rt_val[31]}}, rt_val};
    prod  = mul_a * mul_b;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000/-1 falls out naturally
    // (magnitude 0x80000000, no negation) as lo=0x80000000, hi=0.
    a_neg = is_signed & rs_val[31];
    b_neg = is_signed & rt_val[31];
    a_mag = a_neg ? (~rs_val + 32'd1) : rs_val;
    b_mag = b_neg ? (~rt_val + 32'd1) : rt_val;
    div_b = (b_mag == '0) ? 32'd1 : b_mag;  // keeps the divider defined on /0
    q_mag = a_mag / div_b;
    r_mag = a_mag % div_b;
    quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              pend_wr_d = (rt_val != '0);  // divide by zero leaves HI/LO alone
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      default: begin  // S_BUSY: start, mthi and mtlo are ignored here
`ifdef MD_ABORT_EN
        if (abort) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
        end else
`endif
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed scenarios plus randomized operations checked
// against a behavioural HI/LO model built on 64-bit integer arithmetic.

module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
`ifdef MD_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Model of the architectural HI/LO state.
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
`ifdef MD_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: applies one md_op to (h,l) and reports the expected busy length.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l,
                                 output int unsigned ncyc);
    longint          sp, sa, sb, sq, sr;
    longint unsigned up, ua, ub, uq, ur;
    ncyc = 0;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32]; l = sp[31:0]; ncyc = MC;
      end
      3'd1: begin
        ua = longint'(a); ub = longint'(b);
        up = ua * ub;
        h = up[63:32]; l = up[31:0]; ncyc = MC;
      end
      3'd2: begin
        if (b != 0) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          sq = sa / sb; sr = sa % sb;
          l = sq[31:0]; h = sr[31:0];
        end
        ncyc = DC;
      end
      3'd3: begin
        if (b != 0) begin
          ua = longint'(a); ub = longint'(b);
          uq = ua / ub; ur = ua % ub;
          l = uq[31:0]; h = ur[31:0];
        end
        ncyc = DC;
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Presents one start for a single edge, then parks the inputs on a no-op.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    step();
    start = 1'b0; md_op = 3'b111; rs_val = $urandom; rt_val = $urandom;
  endtask

  // Counts busy cycles (bounded) and records whether HI/LO held the pre-op
  // model values with done low throughout. Ends on the first non-busy cycle.
  task automatic measure(output int unsigned ncyc, output bit hold_ok);
    ncyc = 0; hold_ok = 1'b1;
    while (busy === 1'b1 && ncyc < 200) begin
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0) hold_ok = 1'b0;
      ncyc++;
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; md_op = 3'b111; rs_val = '0; rt_val = '0;
`ifdef MD_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
    n_chk++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
    step(); step();
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    step();
  endtask

  task automatic test_mult();
    int unsigned n, nm; bit ok;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    measure(n, ok);
    ref_op(3'd0, 32'hFFFF_FFFD, 32'd5, m_hi, m_lo, nm);
    n_chk++; if (n !== MC) $display("FAIL mult_busy_len: got %0d want %0d", n, MC); else n_pass++;
    n_chk++; if (!ok) $display("FAIL mult_hold: hi/lo/done changed during busy"); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL mult_done: got %b want 1", done); else n_pass++;
    n_chk++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else n_pass++;
    n_chk++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo: got %h want fffffff1", lo); else n_pass++;
    step();
    n_chk++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_multu();
    int unsigned n, nm; bit ok;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    measure(n, ok);
    ref_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo, nm);
    n_chk++; if (n !== MC) $display("FAIL multu_busy_len: got %0d want %0d", n, MC); else n_pass++;
    n_chk++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else n_pass++;
    n_chk++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h want 00000001", lo); else n_pass++;
    step();
  endtask

  task automatic test_div();
    int unsigned n, nm; bit ok;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);  // -7 / 2
    measure(n, ok);
    ref_op(3'd2, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo, nm);
    n_chk++; if (n !== DC) $display("FAIL div_busy_len: got %0d want %0d", n, DC); else n_pass++;
    n_chk++; if (!ok) $display("FAIL div_hold: hi/lo/done changed during busy"); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL div_done: got %b want 1", done); else n_pass++;
    n_chk++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", lo); else n_pass++;
    n_chk++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", hi); else n_pass++;
    step();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    measure(n, ok);
    ref_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, m_hi, m_lo, nm);
    n_chk++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else n_pass++;
    n_chk++; if (hi !== 32'h0) $display("FAIL div_ovf_hi: got %h want 00000000", hi); else n_pass++;
    step();
  endtask

  task automatic test_div_zero_mt();
    int unsigned n; bit ok;
    issue(3'd4, 32'h1234, $urandom);
    m_hi = 32'h1234;
    n_chk++; if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mthi: got hi=%h busy=%b done=%b want 1234/0/0", hi, busy, done); else n_pass++;
    issue(3'd5, 32'h5678, $urandom);
    m_lo = 32'h5678;
    n_chk++; if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b want 1234/5678/0/0", hi, lo, busy, done); else n_pass++;
    issue(3'd2, $urandom, 32'h0);
    measure(n, ok);
    n_chk++; if (n !== DC) $display("FAIL divz_busy_len: got %0d want %0d", n, DC); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL divz_done: got %b want 1", done); else n_pass++;
    n_chk++; if (hi !== 32'h1234 || lo !== 32'h5678)
      $display("FAIL divz_hilo: got hi=%h lo=%h want 1234/5678", hi, lo); else n_pass++;
    step();
    issue(3'd3, $urandom, 32'h0);
    measure(n, ok);
    n_chk++; if (n !== DC || done !== 1'b1 || hi !== 32'h1234 || lo !== 32'h5678)
      $display("FAIL divuz: got n=%0d done=%b hi=%h lo=%h want %0d/1/1234/5678", n, done, hi, lo, DC); else n_pass++;
    step();
  endtask

  task automatic test_undefined_op();
    for (int unsigned op = 6; op < 8; op++) begin
      issue(3'(op), $urandom, $urandom);
      n_chk++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo)
        $display("FAIL undef_op%0d: got busy=%b done=%b hi=%h lo=%h want 0/0/%h/%h",
                 op, busy, done, hi, lo, m_hi, m_lo); else n_pass++;
      step();
    end
  endtask

  task automatic test_ignore_busy();
    int unsigned n, nm; bit ok;
    logic [31:0] a, b, eh, el;
    a = $urandom; b = $urandom;
    issue(3'd0, a, b);
    start = 1'b1; md_op = 3'd2; rs_val = 32'd9; rt_val = 32'd0;
    step();
    md_op = 3'd4; rs_val = 32'hDEAD_BEEF;
    step();
    start = 1'b0; md_op = 3'b111;
    n_chk++; if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo)
      $display("FAIL ign_mid: got busy=%b hi=%h lo=%h want 1/%h/%h", busy, hi, lo, m_hi, m_lo); else n_pass++;
    measure(n, ok);
    eh = m_hi; el = m_lo;
    ref_op(3'd0, a, b, eh, el, nm);
    m_hi = eh; m_lo = el;
    n_chk++; if (n + 2 !== MC) $display("FAIL ign_busy_len: got %0d want %0d", n + 2, MC); else n_pass++;
    n_chk++; if (hi !== m_hi || lo !== m_lo || done !== 1'b1)
      $display("FAIL ign_result: got hi=%h lo=%h done=%b want %h/%h/1", hi, lo, done, m_hi, m_lo); else n_pass++;
    step();
  endtask

  task automatic test_async_reset();
    int unsigned n, nm; bit ok;
    issue(3'd3, 32'd100, 32'd7);
    step(); step();  // now in busy cycle 3
    start = 1'b1; md_op = 3'd0; rs_val = 32'd6; rt_val = 32'd7;
    step();
    start = 1'b0; md_op = 3'b111;
    n_chk++; if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo)
      $display("FAIL rst_ign: got busy=%b hi=%h lo=%h want 1/%h/%h", busy, hi, lo, m_hi, m_lo); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("FAIL rst_async: got busy=%b done=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    issue(3'd0, 32'd6, 32'd7);
    measure(n, ok);
    ref_op(3'd0, 32'd6, 32'd7, m_hi, m_lo, nm);
    n_chk++; if (n !== MC || lo !== 32'd42 || hi !== 32'h0 || done !== 1'b1)
      $display("FAIL rst_after: got n=%0d hi=%h lo=%h done=%b want %0d/0/0000002a/1", n, hi, lo, done, MC); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int unsigned n, nm; bit ok;
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom_range(1, 1000); c = $urandom; d = $urandom;
    issue(3'd3, a, b);
    measure(n, ok);
    ref_op(3'd3, a, b, m_hi, m_lo, nm);
    n_chk++; if (done !== 1'b1 || hi !== m_hi || lo !== m_lo)
      $display("FAIL b2b_first: got done=%b hi=%h lo=%h want 1/%h/%h", done, hi, lo, m_hi, m_lo); else n_pass++;
    issue(3'd1, c, d);  // start in the done cycle
    n_chk++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done); else n_pass++;
    measure(n, ok);
    ref_op(3'd1, c, d, m_hi, m_lo, nm);
    n_chk++; if (n !== MC || !ok || hi !== m_hi || lo !== m_lo)
      $display("FAIL b2b_second: got n=%0d hold=%0d hi=%h lo=%h want %0d/1/%h/%h", n, ok, hi, lo, MC, m_hi, m_lo); else n_pass++;
    step();
  endtask

  task automatic test_random();
    int unsigned n, nm; bit ok;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(0, 3));
        1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      eh = m_hi; el = m_lo;
      ref_op(op, a, b, eh, el, nm);
      issue(op, a, b);
      if (nm != 0) begin
        measure(n, ok);
        m_hi = eh; m_lo = el;
        n_chk++; if (n !== nm || !ok || done !== 1'b1 || hi !== m_hi || lo !== m_lo)
          $display("FAIL rnd%0d op=%0d a=%h b=%h: got n=%0d hold=%0d done=%b hi=%h lo=%h want %0d/1/1/%h/%h",
                   i, op, a, b, n, ok, done, hi, lo, nm, m_hi, m_lo); else n_pass++;
      end else begin
        m_hi = eh; m_lo = el;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo)
          $display("FAIL rnd%0d op=%0d a=%h: got busy=%b done=%b hi=%h lo=%h want 0/0/%h/%h",
                   i, op, a, busy, done, hi, lo, m_hi, m_lo); else n_pass++;
      end
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

`ifdef MD_ABORT_EN
  task automatic test_abort();
    int unsigned n, nm; bit ok;
    issue(3'd2, 32'd1000, 32'd3);
    step();  // busy cycle 2
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL abort_busy: got busy=%b done=%b hi=%h lo=%h want 0/0/%h/%h", busy, done, hi, lo, m_hi, m_lo); else n_pass++;
    for (int k = 0; k < 12; k++) step();
    n_chk++; if (done !== 1'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL abort_nodone: got done=%b hi=%h lo=%h want 0/%h/%h", done, hi, lo, m_hi, m_lo); else n_pass++;
    abort = 1'b1;
    issue(3'd0, 32'd11, 32'd13);
    abort = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL abort_idle_start: got busy=%b want 1", busy); else n_pass++;
    measure(n, ok);
    ref_op(3'd0, 32'd11, 32'd13, m_hi, m_lo, nm);
    n_chk++; if (n !== MC || lo !== 32'd143 || hi !== 32'h0)
      $display("FAIL abort_idle_result: got n=%0d hi=%h lo=%h want %0d/0/0000008f", n, hi, lo, MC); else n_pass++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero_mt();
    test_undefined_op();
    test_ignore_busy();
    test_back_to_back();
    test_random();
`ifdef MD_ABORT_EN
    test_abort();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
